// File: rtl/bus_cycle_terminator.sv
// bus_cycle_terminator: 68030 bus-cycle termination stage behind the Mackerel-30
// address decoder. It adds per-device wait states before DSACK0_n, autovectors
// interrupt-acknowledge cycles, and raises BERR_n on any cycle left unterminated.
module bus_cycle_terminator #(
    parameter int unsigned ROM_WAIT   = 3,
    parameter int unsigned SRAM_WAIT  = 1,
    parameter int unsigned DUART_WAIT = 4,
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       AS_n,
    input  logic [2:0] FC,
    input  logic       CS_ROM_n,
    input  logic       CS_SRAM_n,
    input  logic       CS_DUART_n,
    output logic       DSACK0_n,
    output logic       DSACK1_n,
    output logic       AVEC_n,
    output logic       BERR_n,
    output logic       BERR_FLAG,
    output logic       BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_BERR
    } state_t;

    typedef enum logic [1:0] {
        KIND_MEM,
        KIND_IACK,
        KIND_UNMAPPED
    } kind_t;

    // The timeout counter is cleared at the start edge, so its value before
    // edge N+k is k-1; matching TIMEOUT-1 fires BERR at edge N+TIMEOUT.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [2:0]       FC_CPU   = 3'b111;

    state_t           state;
    kind_t            kind;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] sel_wait_c;
    kind_t            sel_kind_c;

    // Wait-state count and cycle kind from the decoder, ROM > SRAM > DUART
    always_comb begin
        sel_wait_c = '0;
        sel_kind_c = KIND_UNMAPPED;
        if (!CS_ROM_n) begin
            sel_wait_c = CNT_W'(ROM_WAIT);
            sel_kind_c = KIND_MEM;
        end else if (!CS_SRAM_n) begin
            sel_wait_c = CNT_W'(SRAM_WAIT);
            sel_kind_c = KIND_MEM;
        end else if (!CS_DUART_n) begin
            sel_wait_c = CNT_W'(DUART_WAIT);
            sel_kind_c = KIND_MEM;
        end else if (FC == FC_CPU) begin
            sel_kind_c = KIND_IACK;
        end
    end

    // Cycle FSM with registered termination strobes
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            kind      <= KIND_MEM;
            wait_cnt  <= '0;
            tmo_cnt   <= '0;
            DSACK0_n  <= 1'b1;
            DSACK1_n  <= 1'b1;
            AVEC_n    <= 1'b1;
            BERR_n    <= 1'b1;
            BERR_FLAG <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            DSACK1_n <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (!AS_n) begin
                        state    <= ST_WAIT;
                        wait_cnt <= sel_wait_c;
                        kind     <= sel_kind_c;
                        tmo_cnt  <= '0;
                        BUSY     <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    tmo_cnt <= tmo_cnt + CNT_W'(1);
                    if (AS_n) begin
                        // Aborted before termination: leave quietly
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end else if (kind == KIND_MEM && wait_cnt == '0) begin
                        // Ack is checked before timeout so it wins a tie
                        state    <= ST_ACK;
                        DSACK0_n <= 1'b0;
                    end else if (kind == KIND_IACK) begin
                        state  <= ST_ACK;
                        AVEC_n <= 1'b0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state     <= ST_BERR;
                        BERR_n    <= 1'b0;
                        BERR_FLAG <= 1'b1;
                    end else if (kind == KIND_MEM) begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                ST_ACK, ST_BERR: begin
                    if (AS_n) begin
                        state    <= ST_IDLE;
                        DSACK0_n <= 1'b1;
                        AVEC_n   <= 1'b1;
                        BERR_n   <= 1'b1;
                        BUSY     <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_cycle_terminator.sv
// Testbench for bus_cycle_terminator: expected output vectors are queued as each
// edge's stimulus is applied and compared after that edge.
module tb_bus_cycle_terminator;

    localparam int unsigned ROM_WAIT   = 3;
    localparam int unsigned SRAM_WAIT  = 1;
    localparam int unsigned DUART_WAIT = 4;
    localparam int unsigned TIMEOUT    = 64;

    logic       CLK;
    logic       RST;
    logic       AS_n;
    logic [2:0] FC;
    logic       CS_ROM_n;
    logic       CS_SRAM_n;
    logic       CS_DUART_n;
    logic       DSACK0_n;
    logic       DSACK1_n;
    logic       AVEC_n;
    logic       BERR_n;
    logic       BERR_FLAG;
    logic       BUSY;

    int total;
    int bad;
    logic flag_exp;

    logic [5:0] exp_q[$];
    string      tag_q[$];

    bus_cycle_terminator #(
        .ROM_WAIT  (ROM_WAIT),
        .SRAM_WAIT (SRAM_WAIT),
        .DUART_WAIT(DUART_WAIT),
        .TIMEOUT   (TIMEOUT),
        .CNT_W     (8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .AS_n      (AS_n),
        .FC        (FC),
        .CS_ROM_n  (CS_ROM_n),
        .CS_SRAM_n (CS_SRAM_n),
        .CS_DUART_n(CS_DUART_n),
        .DSACK0_n  (DSACK0_n),
        .DSACK1_n  (DSACK1_n),
        .AVEC_n    (AVEC_n),
        .BERR_n    (BERR_n),
        .BERR_FLAG (BERR_FLAG),
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Vector order: {DSACK0_n, DSACK1_n, AVEC_n, BERR_n, BERR_FLAG, BUSY}
    function automatic logic [5:0] vec(input logic dsack0, input logic avec,
                                       input logic berr, input logic flag,
                                       input logic busy);
        return {dsack0, 1'b1, avec, berr, flag, busy};
    endfunction

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b exp=%b (dsack0,dsack1,avec,berr,flag,busy)",
                     tag, got, exp);
        end
    endtask

    // Apply one edge's inputs, queue its expectation, clock, then compare
    task automatic step(input string tag, input logic rst, input logic as_n,
                        input logic [2:0] fc, input logic [2:0] cs_n,
                        input logic [5:0] exp);
        logic [5:0] e;
        string      t;
        RST        = rst;
        AS_n       = as_n;
        FC         = fc;
        CS_ROM_n   = cs_n[2];
        CS_SRAM_n  = cs_n[1];
        CS_DUART_n = cs_n[0];
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, {DSACK0_n, DSACK1_n, AVEC_n, BERR_n, BERR_FLAG, BUSY}, e);
    endtask

    task automatic idle_edges(input string tag, input int n);
        for (int i = 0; i < n; i++)
            step(tag, 1'b0, 1'b1, 3'b001, 3'b111, vec(1, 1, 1, flag_exp, 0));
    endtask

    // Memory cycle: chip selects only valid at the start edge, then dropped.
    // DSACK0_n is expected low from edge N+1+w, held `hold` extra edges.
    task automatic mem_cycle(input string tag, input logic [2:0] cs_n,
                             input int w, input int hold);
        for (int k = 0; k <= w + 1 + hold; k++)
            step(tag, 1'b0, 1'b0, 3'b001, (k == 0) ? cs_n : 3'b111,
                 vec((k >= 1 + w) ? 1'b0 : 1'b1, 1, 1, flag_exp, 1));
        step({tag, "_rel"}, 1'b0, 1'b1, 3'b001, 3'b111, vec(1, 1, 1, flag_exp, 0));
        idle_edges({tag, "_idle"}, 1);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        flag_exp = 1'b0;

        // Reset, then a ROM cycle interrupted by a 2-edge reset
        step("rst0", 1'b1, 1'b1, 3'b001, 3'b111, vec(1, 1, 1, 0, 0));
        step("rst1", 1'b1, 1'b1, 3'b001, 3'b111, vec(1, 1, 1, 0, 0));
        idle_edges("idle0", 2);
        step("rom_start", 1'b0, 1'b0, 3'b001, 3'b011, vec(1, 1, 1, 0, 1));
        step("rom_wait", 1'b0, 1'b0, 3'b001, 3'b011, vec(1, 1, 1, 0, 1));
        step("rst_mid0", 1'b1, 1'b0, 3'b001, 3'b011, vec(1, 1, 1, 0, 0));
        step("rst_mid1", 1'b1, 1'b0, 3'b001, 3'b011, vec(1, 1, 1, 0, 0));
        idle_edges("post_rst", 2);

        // SRAM cycle, one wait state, held a few edges after ack
        mem_cycle("sram", 3'b101, SRAM_WAIT, 2);

        // ROM and DUART selected together: ROM wait count must win
        mem_cycle("rom_prio", 3'b010, ROM_WAIT, 1);

        // Plain DUART cycle
        mem_cycle("duart", 3'b110, DUART_WAIT, 0);

        // Interrupt acknowledge: AVEC_n from N+1, DSACK0_n stays high
        step("iack0", 1'b0, 1'b0, 3'b111, 3'b111, vec(1, 1, 1, 0, 1));
        for (int k = 1; k <= 3; k++)
            step("iack", 1'b0, 1'b0, 3'b111, 3'b111, vec(1, 0, 1, 0, 1));
        step("iack_rel", 1'b0, 1'b1, 3'b111, 3'b111, vec(1, 1, 1, 0, 0));
        idle_edges("iack_idle", 1);

        // Unmapped cycle: BERR_n from N+TIMEOUT, flag sticks afterwards
        for (int k = 0; k <= int'(TIMEOUT) + 2; k++) begin
            if (k >= int'(TIMEOUT)) flag_exp = 1'b1;
            step((k == int'(TIMEOUT) - 1) ? "tmo_edge_m1" : "tmo", 1'b0, 1'b0, 3'b101,
                 3'b111, vec(1, 1, (k >= int'(TIMEOUT)) ? 1'b0 : 1'b1, flag_exp, 1));
        end
        step("berr_rel", 1'b0, 1'b1, 3'b101, 3'b111, vec(1, 1, 1, 1, 0));
        idle_edges("berr_idle", 2);
        mem_cycle("sram_after_berr", 3'b101, SRAM_WAIT, 1);

        // DUART cycle aborted at N+2 before its ack, then a normal SRAM cycle
        step("abort0", 1'b0, 1'b0, 3'b001, 3'b110, vec(1, 1, 1, flag_exp, 1));
        step("abort1", 1'b0, 1'b0, 3'b001, 3'b110, vec(1, 1, 1, flag_exp, 1));
        step("abort_rel", 1'b0, 1'b1, 3'b001, 3'b110, vec(1, 1, 1, flag_exp, 0));
        idle_edges("abort_idle", 6);
        mem_cycle("sram_after_abort", 3'b101, SRAM_WAIT, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
